// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch sequencer for the multicycle CPU.
// Reads the PC, fetches one word from instruction memory with a req/ack
// read, holds it in the instruction register for decode, and is the only
// writer of the program counter (PC+4 advance and branch/jump redirects).
// Optional feature macro: FETCH_TIMEOUT_EN adds a REQ timeout counter and a
// sticky FAULT state; without it REQ waits indefinitely and fetch_fault=0.
//
// Handshakes:
//   memory : mem_req/mem_addr are registered and held stable until a cycle
//            with mem_ack=1 while mem_req=1; mem_ack with mem_req=0 is ignored.
//   decode : ir is transferred in a cycle where ir_valid=1 and ir_ready=1;
//            ir and ir_valid hold while ir_valid=1 and ir_ready=0.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_we,
  output logic [31:0] pc_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        squash_q, squash_d;

  logic        in_req;
  logic        in_hold;
  logic        ack_take;     // returned word is kept and PC advances
  logic        ack_drop;     // returned word belongs to a squashed path
  logic        redir_live;   // redirect is honoured this cycle
  logic        hold_leave;   // HOLD ends: decode took ir or it was killed
  logic        timeout_hit;

  assign in_req     = (state_q == S_REQ);
  assign in_hold    = (state_q == S_HOLD);
  assign ack_take   = in_req && mem_ack && !squash_q && !redirect;
  assign ack_drop   = in_req && mem_ack && (squash_q || redirect);
  assign redir_live = redirect && (in_req || in_hold);
  assign hold_leave = in_hold && (redirect || (ir_valid_q && ir_ready));

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       fetch_fault_q, fetch_fault_d;

  // The last cycle of a REQ that has run out of time without an ack.
  assign timeout_hit = in_req && !mem_ack && ((cnt_q + 8'd1) == TIMEOUT_LIM);

  // Counter restarts on every REQ entry and counts ack-less REQ cycles; fault is sticky.
  always_comb begin
    cnt_d         = cnt_q;
    fetch_fault_d = fetch_fault_q | timeout_hit;
    if (state_d == S_REQ && !in_req) begin
      cnt_d = 8'd0;
    end else if (ack_drop) begin
      cnt_d = 8'd0;
    end else if (in_req && !mem_ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Timeout counter and fault flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= 8'd0;
      fetch_fault_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign fetch_fault = fetch_fault_q;
`else
  // Timeout limit has no consumer in this build.
  logic [7:0] unused_timeout_lim;
  assign unused_timeout_lim = TIMEOUT_LIM;
  assign timeout_hit        = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  // State and datapath registers; everything returns to reset values on rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0000_0000;
      ir_q       <= 32'h0000_0000;
      ir_valid_q <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      squash_q   <= squash_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ: begin
        if (ack_take) begin
          state_d = S_HOLD;
        end else if (ack_drop) begin
          state_d = S_REQ;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
        end
      end
      S_HOLD:  if (hold_leave) state_d = S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: request address on REQ entry, IR capture, squash tracking.
  always_comb begin
    mem_req_d  = (state_d == S_REQ);
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    squash_d   = squash_q;

    if (state_q == S_IDLE) begin
      mem_addr_d = RESET_PC;
    end else if (ack_drop || hold_leave) begin
      // A redirect this cycle wins over the PC register, which only updates at the edge.
      mem_addr_d = redirect ? redirect_pc : pc_in;
    end

    if (ack_take) begin
      ir_d       = mem_rdata;
      ir_valid_d = 1'b1;
    end else if (hold_leave) begin
      ir_valid_d = 1'b0;
    end

    if (in_req) begin
      if (mem_ack) begin
        squash_d = 1'b0;
      end else if (redirect) begin
        squash_d = 1'b1;
      end
    end
  end

  // Combinational PC write port; redirect has priority over sequential advance.
  always_comb begin
    pc_we   = !rst && (redir_live || ack_take);
    pc_next = 32'h0000_0000;
    if (pc_we) begin
      pc_next = redirect ? redirect_pc : (pc_in + 32'd4);
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed sequences, a vector table and a randomized
// phase against a transaction-level model of the fetch unit.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TMO = 8;
`else
  localparam int unsigned TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in;
  logic        pc_we;
  logic [31:0] pc_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_fault;
  logic [1:0]  dbg_state;

  // Program counter register owned by the environment, plus a test override.
  logic [31:0] pc_reg;
  logic        pc_ovr_en = 1'b0;
  logic [31:0] pc_ovr = 32'h0;
  assign pc_in = pc_ovr_en ? pc_ovr : pc_reg;

  int n_vec = 0;
  int n_bad = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_we(pc_we), .pc_next(pc_next),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .fetch_fault(fetch_fault), .dbg_state(dbg_state)
  );

  // Clock and PC register.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) pc_reg <= RESET_PC;
    else if (pc_we) pc_reg <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1111_0000 + a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_next;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[5];

  // Transaction-level reference model state.
  logic [31:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_idle;
  logic        m_fetching;
  logic        m_pend;
  logic [31:0] cur_ir;

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    int lat;
    int cnt;
    logic holding, fetching, next_fetching, exp_we;
    logic [31:0] exp_next;

    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100};
    vecs[1] = '{32'hFFFF_FFFC, 1'b0, 32'h0,         32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    vecs[2] = '{32'h0000_0200, 1'b1, 32'h0000_0300, 32'hAAAA_5555, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0300};
    vecs[3] = '{32'h7FFF_FFFC, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b1, 32'h8000_0000, 1'b1, 32'h7FFF_FFFC};
    vecs[4] = '{32'h0000_0010, 1'b1, 32'hFFFF_FFF0, 32'h0BAD_0BAD, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'hFFFF_FFF0};

    // Reset values.
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_fault", fetch_fault, 0);
    chk("rst_pc_we", pc_we, 0);
    chk("rst_pc_next", pc_next, 0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mem_req", mem_req, 0);
    cyc();

    // Zero-wait fetches from reset, decode always ready.
    ir_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_ack   = 1'b1;
      mem_rdata = mem_word(mem_addr);
      @(negedge clk);
      chk("seq_mem_req", mem_req, 1);
      chk("seq_mem_addr", mem_addr, 32'(4 * k));
      chk("seq_pc_we", pc_we, 1);
      chk("seq_pc_next", pc_next, 32'(4 * k + 4));
      cyc();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("seq_ir", ir, 32'h1111_0000 + 32'(4 * k));
      chk("seq_ir_valid", ir_valid, 1);
      chk("seq_hold_req", mem_req, 0);
      chk("seq_pc", pc_reg, 32'(4 * k + 4));
      cyc();
    end

    // Decode stall for 5 cycles in HOLD.
    ir_ready  = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = mem_word(mem_addr);
    @(negedge clk);
    cyc();
    mem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_ir", ir, 32'h1111_000C);
      chk("stall_valid", ir_valid, 1);
      chk("stall_req", mem_req, 0);
      chk("stall_pc", pc_reg, 32'h10);
      chk("stall_pc_we", pc_we, 0);
      cyc();
    end
    ir_ready = 1'b1;
    @(negedge clk);
    cyc();
    @(negedge clk);
    chk("unstall_req", mem_req, 1);
    chk("unstall_addr", mem_addr, 32'h10);
    chk("unstall_valid", ir_valid, 0);
    cyc();

    // Redirect during REQ, ack arrives three cycles later.
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    chk("redq_pc_we", pc_we, 1);
    chk("redq_pc_next", pc_next, 32'h40);
    cyc();
    redirect = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("redq_req_held", mem_req, 1);
      chk("redq_addr_held", mem_addr, 32'h10);
      chk("redq_pc_we_idle", pc_we, 0);
      cyc();
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_0000;
    @(negedge clk);
    chk("redq_ack_pc_we", pc_we, 0);
    cyc();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("redq_valid", ir_valid, 0);
    chk("redq_ir", ir, 32'h1111_000C);
    chk("redq_req", mem_req, 1);
    chk("redq_addr", mem_addr, 32'h40);
    chk("redq_pc", pc_reg, 32'h40);
    cyc();

    // Redirect coincident with ack.
    mem_ack     = 1'b1;
    mem_rdata   = mem_word(mem_addr);
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    @(negedge clk);
    chk("reda_pc_we", pc_we, 1);
    chk("reda_pc_next", pc_next, 32'h80);
    cyc();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("reda_ir", ir, 32'h1111_000C);
    chk("reda_valid", ir_valid, 0);
    chk("reda_addr", mem_addr, 32'h80);
    chk("reda_req", mem_req, 1);
    chk("reda_pc", pc_reg, 32'h80);
    cyc();

    // Vector table: one acked fetch per record with a forced pc_in.
    cur_ir = 32'h1111_000C;
    for (int i = 0; i < 5; i++) begin
      pc_ovr_en   = 1'b1;
      pc_ovr      = vecs[i].pc;
      redirect    = vecs[i].redir;
      redirect_pc = vecs[i].tgt;
      mem_ack     = 1'b1;
      mem_rdata   = vecs[i].rdata;
      ir_ready    = 1'b1;
      @(negedge clk);
      chk("tbl_pc_we", pc_we, vecs[i].exp_we);
      chk("tbl_pc_next", pc_next, vecs[i].exp_next);
      cyc();
      redirect = 1'b0;
      mem_ack  = 1'b0;
      if (vecs[i].exp_valid) cur_ir = vecs[i].rdata;
      @(negedge clk);
      chk("tbl_valid", ir_valid, vecs[i].exp_valid);
      chk("tbl_ir", ir, cur_ir);
      if (vecs[i].exp_valid) begin
        cyc();
        @(negedge clk);
      end
      chk("tbl_addr", mem_addr, vecs[i].exp_addr);
      chk("tbl_req", mem_req, 1);
      cyc();
    end
    pc_ovr_en = 1'b0;

    // Reset in the middle of a fetch.
    rst         = 1'b1;
    mem_ack     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h55C;
    @(negedge clk);
    chk("midrst_pc_we", pc_we, 0);
    chk("midrst_pc_next", pc_next, 0);
    cyc();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    @(negedge clk);
    chk("midrst_req", mem_req, 0);
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_valid", ir_valid, 0);
    chk("midrst_pc", pc_reg, RESET_PC);
    cyc();
    rst = 1'b0;

    // Randomized phase: model tracks the architectural PC and delivered words.
    m_pc       = RESET_PC;
    m_idle     = 1'b1;
    m_fetching = 1'b0;
    m_pend     = 1'b0;
    exp_q.delete();
    lat = 0;
    for (int n = 0; n < 3000; n++) begin
      fetching = m_fetching;
      holding  = (exp_q.size() != 0);
      ir_ready = ($urandom_range(0, 3) != 0);
      redirect = (fetching || holding) && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = $urandom & 32'hFFFF_FFFC;
      else redirect_pc = 32'($urandom_range(0, 255)) << 2;
      if (fetching) begin
        if (lat == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          lat       = $urandom_range(0, 3);
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
          lat--;
        end
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      @(negedge clk);
      chk("rnd_mem_req", mem_req, fetching);
      chk("rnd_valid", ir_valid, holding);
      if (holding) chk("rnd_ir", ir, exp_q[0]);
      chk("rnd_pc", pc_reg, m_pc);
      exp_we        = 1'b0;
      exp_next      = 32'h0;
      next_fetching = fetching;
      if (m_idle) begin
        next_fetching = 1'b1;
        m_idle        = 1'b0;
      end
      if (fetching && mem_ack) begin
        if (redirect || m_pend) begin
          m_pend = 1'b0;
        end else begin
          chk("rnd_addr", mem_addr, m_pc);
          exp_q.push_back(mem_word(m_pc));
          m_pc          = m_pc + 32'd4;
          exp_we        = 1'b1;
          exp_next      = m_pc;
          next_fetching = 1'b0;
        end
      end else if (fetching && redirect) begin
        m_pend = 1'b1;
      end
      if (holding && (ir_ready || redirect)) begin
        void'(exp_q.pop_front());
        next_fetching = 1'b1;
      end
      if (redirect) begin
        m_pc     = redirect_pc;
        exp_we   = 1'b1;
        exp_next = redirect_pc;
      end
      chk("rnd_pc_we", pc_we, exp_we);
      chk("rnd_pc_next", pc_next, exp_next);
      m_fetching = next_fetching;
      cyc();
    end
    redirect = 1'b0;
    mem_ack  = 1'b0;

    // Memory that never acknowledges.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt = 0;
    for (int c = 0; c < 60 && !fetch_fault; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      cyc();
    end
    chk("tmo_req_cycles", 32'(cnt), 32'(TMO));
    chk("tmo_fault", fetch_fault, 1);
    chk("tmo_req_drop", mem_req, 0);
    redirect    = 1'b1;
    redirect_pc = 32'h123C;
    mem_ack     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fault_pc_we", pc_we, 0);
      chk("fault_sticky", fetch_fault, 1);
      chk("fault_req", mem_req, 0);
      cyc();
    end
    redirect = 1'b0;
    mem_ack  = 1'b0;
    rst      = 1'b1;
    cyc();
    @(negedge clk);
    chk("fault_cleared", fetch_fault, 0);
    cyc();
    rst = 1'b0;
`else
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      cyc();
    end
    chk("wait_req_cycles", 32'(cnt), 32'd299);
    chk("wait_req", mem_req, 1);
    chk("wait_addr", mem_addr, RESET_PC);
    chk("wait_fault", fetch_fault, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
